// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready input, out_valid pulse and persistent C/Z/N/V flags.
// Define ALU_MUL_EN to build the Width-cycle shift-add multiplier (OpCode 1001) and its MUL_BUSY state.
module seq_alu #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic [3:0]       OpCode,
  input  logic [1:0]       ra,
  output logic             out_valid,
  output logic [Width-1:0] Out,
  output logic [Width-1:0] Hi,
  output logic             C,
  output logic             Z,
  output logic             N,
  output logic             V
);
  localparam int M = Width - 1;
  localparam logic [Width:0] ONE = (Width+1)'(1);

  logic [Width-1:0] out_q, out_d, hi_q, hi_d;
  logic             c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic             valid_q, valid_d;
  logic             accept, upd_zn;
  logic [Width:0]   sum, ext_a, ext_b, ext_c;

  assign ext_a = {1'b0, A};
  assign ext_b = {1'b0, B};
  assign ext_c = {{Width{1'b0}}, c_q};

`ifdef ALU_MUL_EN
  localparam int CntW = (Width > 1) ? $clog2(Width) : 1;

  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [Width-1:0]     mcand_q, mcand_d;
  logic [2*Width-1:0]   prod_q, prod_d, prod_nx;
  logic [Width:0]       mul_sum;
  logic                 mul_start, mul_done;

  assign mul_start = accept && (OpCode == 4'b1001);
  assign mul_done  = (state_q == MUL_BUSY) && (cnt_q == CntW'(Width - 1));

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (mul_start) state_d = MUL_BUSY;
      MUL_BUSY: if (mul_done)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // Low half of prod holds the remaining multiplier bits; product shifts in from the top.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*Width-1:Width]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nx = {mul_sum, prod_q[Width-1:1]};
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (mul_start) begin
      cnt_d   = '0;
      mcand_d = A;
      prod_d  = {{Width{1'b0}}, B};
    end else if (state_q == MUL_BUSY) begin
      cnt_d  = cnt_q + CntW'(1);
      prod_d = prod_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end
`else
  assign in_ready = 1'b1;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    out_d   = out_q;
    hi_d    = hi_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    valid_d = 1'b0;
    upd_zn  = 1'b0;
    sum     = '0;
    if (accept) begin
      valid_d = 1'b1;
      hi_d    = '0;
      out_d   = B;
      case (OpCode)
        4'b0010: begin
          sum = ext_a + ext_b;
          out_d = sum[M:0]; c_d = sum[Width]; upd_zn = 1'b1;
          v_d = (A[M] == B[M]) && (sum[M] != A[M]);
        end
        4'b0011: begin
          sum = ext_a - ext_b;
          out_d = sum[M:0]; c_d = sum[Width]; upd_zn = 1'b1;
          v_d = (A[M] != B[M]) && (sum[M] != A[M]);
        end
        4'b0111: begin
          case (ra)
            2'd0: begin
              sum = ext_a + ext_b + ext_c;
              out_d = sum[M:0]; c_d = sum[Width]; upd_zn = 1'b1;
              v_d = (A[M] == B[M]) && (sum[M] != A[M]);
            end
            2'd1: begin
              sum = ext_a - ext_b - ext_c;
              out_d = sum[M:0]; c_d = sum[Width]; upd_zn = 1'b1;
              v_d = (A[M] != B[M]) && (sum[M] != A[M]);
            end
            default: ;
          endcase
        end
        4'b0100: begin out_d = A & B; upd_zn = 1'b1; end
        4'b0101: begin out_d = A | B; upd_zn = 1'b1; end
        4'b0110: begin
          case (ra)
            2'd0:    begin out_d = {B[M-1:0], c_q}; c_d = B[M]; end
            2'd1:    begin out_d = {c_q, B[M:1]};   c_d = B[0]; end
            2'd2:    begin out_d = out_q; c_d = 1'b1; end
            default: begin out_d = out_q; c_d = 1'b0; end
          endcase
        end
        4'b1000: begin
          upd_zn = 1'b1;
          case (ra)
            2'd0: out_d = ~B;
            2'd1: begin sum = {1'b0, ~B} + ONE; out_d = sum[M:0]; end
            2'd2: begin
              sum = ext_b + ONE;
              out_d = sum[M:0]; c_d = sum[Width]; v_d = ~B[M] & sum[M];
            end
            default: begin
              sum = ext_b - ONE;
              out_d = sum[M:0]; c_d = sum[Width]; v_d = B[M] & ~sum[M];
            end
          endcase
        end
`ifdef ALU_MUL_EN
        4'b1001: begin
          valid_d = 1'b0;
          out_d   = out_q;
          hi_d    = hi_q;
        end
`endif
        default: ;
      endcase
    end
`ifdef ALU_MUL_EN
    if (mul_done) begin
      valid_d = 1'b1;
      out_d   = prod_nx[M:0];
      hi_d    = prod_nx[2*Width-1:Width];
      z_d     = (prod_nx == '0);
      n_d     = prod_nx[2*Width-1];
      c_d     = (prod_nx[2*Width-1:Width] != '0);
    end
`endif
    if (upd_zn) begin
      z_d = (out_d == '0);
      n_d = out_d[M];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_q   <= '0;
      hi_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      hi_q    <= hi_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      valid_q <= valid_d;
    end
  end

  assign Out       = out_q;
  assign Hi        = hi_q;
  assign C         = c_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = v_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random operations on seq_alu compared against an integer-arithmetic model.
module tb_seq_alu;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);
`ifdef ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready, out_valid, C, Z, N, V;
  logic [W-1:0] A = '0, B = '0, Out, Hi;
  logic [3:0]   OpCode = '0;
  logic [1:0]   ra = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int m_out, m_hi;
  bit m_c, m_z, m_n, m_v;

  seq_alu #(.Width(W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .OpCode(OpCode), .ra(ra),
    .out_valid(out_valid), .Out(Out), .Hi(Hi),
    .C(C), .Z(Z), .N(N), .V(V)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= HALF) ? x - (1 << W) : x;
  endfunction

  function automatic bit ovf(input int s);
    return (s < -HALF) || (s > HALF - 1);
  endfunction

  // Applies one accepted operation to the architectural state; returns 1 for a multi-cycle MUL.
  function automatic bit model_op(input bit [3:0] op, input bit [1:0] r, input int a, input int b);
    int s;
    int cin = int'(m_c);
    bit zn = 1'b0;
    bit mul = 1'b0;
    m_hi = 0;
    case (op)
      4'h2: begin s = a + b; m_out = s & MASK; m_c = (s > MASK); m_v = ovf(sx(a) + sx(b)); zn = 1; end
      4'h3: begin m_out = (a - b) & MASK; m_c = (a < b); m_v = ovf(sx(a) - sx(b)); zn = 1; end
      4'h7: begin
        if (r == 0) begin
          s = a + b + cin; m_out = s & MASK; m_c = (s > MASK); m_v = ovf(sx(a) + sx(b) + cin); zn = 1;
        end else if (r == 1) begin
          m_out = (a - b - cin) & MASK; m_c = (a < b + cin); m_v = ovf(sx(a) - sx(b) - cin); zn = 1;
        end else m_out = b;
      end
      4'h4: begin m_out = a & b; zn = 1; end
      4'h5: begin m_out = a | b; zn = 1; end
      4'h6: begin
        case (r)
          2'd0: begin m_out = ((b << 1) | cin) & MASK; m_c = ((b >> (W - 1)) & 1) != 0; end
          2'd1: begin m_out = (b >> 1) | (cin << (W - 1)); m_c = (b & 1) != 0; end
          2'd2: m_c = 1;
          default: m_c = 0;
        endcase
      end
      4'h8: begin
        zn = 1;
        case (r)
          2'd0: m_out = (~b) & MASK;
          2'd1: m_out = (-b) & MASK;
          2'd2: begin m_out = (b + 1) & MASK; m_c = (b == MASK); m_v = ovf(sx(b) + 1); end
          default: begin m_out = (b - 1) & MASK; m_c = (b == 0); m_v = ovf(sx(b) - 1); end
        endcase
      end
      4'h9: begin
        if (MulEn) begin
          s = a * b;
          m_out = s & MASK; m_hi = s >> W;
          m_z = (s == 0); m_n = ((m_hi >> (W - 1)) & 1) != 0; m_c = (m_hi != 0);
          mul = 1;
        end else m_out = b;
      end
      default: m_out = b;
    endcase
    if (zn) begin
      m_z = (m_out == 0);
      m_n = ((m_out >> (W - 1)) & 1) != 0;
    end
    return mul;
  endfunction

  task automatic check_outs(input string tag, input bit exp_valid);
    check({tag, ".out_valid"}, out_valid, exp_valid);
    check({tag, ".in_ready"}, in_ready, 1);
    check({tag, ".Out"}, Out, m_out);
    check({tag, ".Hi"}, Hi, m_hi);
    check({tag, ".C"}, C, m_c);
    check({tag, ".Z"}, Z, m_z);
    check({tag, ".N"}, N, m_n);
    check({tag, ".V"}, V, m_v);
  endtask

  task automatic run_op(input bit [3:0] op, input bit [1:0] r, input int a, input int b);
    string tag;
    int    prev_out;
    bit    mul;
    tag = $sformatf("op%0h.%0d a=%0h b=%0h", op, r, a, b);
    prev_out = m_out;
    A = W'(a); B = W'(b); OpCode = op; ra = r; in_valid = 1'b1;
    @(posedge clk); #1;
    mul = model_op(op, r, a, b);
    if (mul) begin
      for (int i = 0; i < W; i++) begin
        check({tag, " busy.in_ready"}, in_ready, 0);
        check({tag, " busy.out_valid"}, out_valid, 0);
        check({tag, " busy.Out"}, Out, prev_out);
        A = W'($urandom); B = W'($urandom); OpCode = 4'($urandom); ra = 2'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    check_outs(tag, 1'b1);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("idle.out_valid", out_valid, 0);
    check("idle.Out", Out, m_out);
    check("idle.C", C, m_c);
  endtask

  task automatic model_reset();
    m_out = 0; m_hi = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0);
    rstn = 1'b1;

    run_op(4'h2, 0, 'h7F, 'h01);
    check("tp.add.Out", Out, 'h80);
    check("tp.add.V", V, 1);
    idle_cycle();
    run_op(4'h3, 0, 'h10, 'h20);
    check("tp.sub.C", C, 1);
    run_op(4'h7, 1, 'h05, 'h04);
    check("tp.sbc.Z", Z, 1);
    run_op(4'h6, 2, 0, 0);
    run_op(4'h6, 0, 0, 'h80);
    check("tp.rlc.Out", Out, 'h01);
    run_op(4'h6, 1, 0, 'h01);
    check("tp.rrc.Out", Out, 'h80);
    run_op(4'h4, 0, 'hF0, 'h0F);
    check("tp.and.C", C, 1);
    run_op(4'h2, 0, 'hFF, 'h01);
    run_op(4'h7, 0, 'h00, 'h00);
    run_op(4'h8, 3, 0, 'h80);
    run_op(4'h8, 2, 0, 'h7F);
    run_op(4'h8, 1, 0, 'h00);

    run_op(4'h9, 0, 'hFF, 'hFF);
    idle_cycle();
    run_op(4'h9, 0, 3, 7);

`ifdef ALU_MUL_EN
    check("tp.mul.Hi", Hi, 'h00);
    check("tp.mul.Out", Out, 'h15);
    A = 'hFF; B = 'hFF; OpCode = 4'h9; ra = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_outs("midrst", 1'b0);
    rstn = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check("midrst.after.out_valid", out_valid, 0);
      check("midrst.after.in_ready", in_ready, 1);
    end
`else
    check("tp.nomul.Out", Out, 'h07);
    check("tp.nomul.Hi", Hi, 'h00);
`endif

    repeat (300) begin
      run_op(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
